// File: rtl/trainled_pkg.sv
// TrainLED multi-channel pixel: shared receiver types and defaults.
package trainled_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HIGH,
        RX_LOW
    } rx_state_e;

    localparam int DEF_MIN_PULSE  = 2;
    localparam int DEF_THRESH     = 6;
    localparam int DEF_IDLE_TICKS = 48;

    function automatic int frame_bits(input int channels, input int pwm_bits);
        return channels * pwm_bits;
    endfunction

endpackage

// File: rtl/trainled_pwm.sv
// TrainLED PWM back end: free-running counter, pending/duty double buffer
// and per-channel comparators. Channel 0 sits in the MSBs of i_frame.
module trainled_pwm #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_load,
    input  logic [CHANNELS*PWM_BITS-1:0] i_frame,
    output logic [CHANNELS-1:0]          o_led
);

    localparam int FB = CHANNELS * PWM_BITS;

    logic [PWM_BITS-1:0] r_pcnt;
    logic [FB-1:0]       r_pending;
    logic [FB-1:0]       r_duty;
    logic                r_pend_valid;
    logic                w_wrap;

    assign w_wrap = (r_pcnt == '1);

    // Duty only changes on the wrap so no period ever sees a mixed value;
    // a load in the same cycle stays pending for the following wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_pending    <= '0;
            r_duty       <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            if (w_wrap && r_pend_valid) begin
                r_duty       <= r_pending;
                r_pend_valid <= 1'b0;
            end
            if (i_load) begin
                r_pending    <= i_frame;
                r_pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        o_led = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_led[i] = r_pcnt < r_duty[(CHANNELS-1-i)*PWM_BITS +: PWM_BITS];
        end
    end

endmodule

// File: rtl/trainled_nch.sv
// TrainLED multi-channel pixel: synchroniser, pulse-width receiver,
// shadow register and daisy-chain forwarding in front of the PWM block.
module trainled_nch
    import trainled_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int CNT_BITS   = 6,
    parameter int MIN_PULSE  = DEF_MIN_PULSE,
    parameter int THRESH     = DEF_THRESH,
    parameter int IDLE_TICKS = DEF_IDLE_TICKS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    output logic                dout,
    output logic [CHANNELS-1:0] led
);

    localparam int FB   = frame_bits(CHANNELS, PWM_BITS);
    localparam int BC_W = $clog2(FB + 1);

    localparam logic [BC_W-1:0]     FULL      = BC_W'(FB);
    localparam logic [CNT_BITS-1:0] MINP      = CNT_BITS'(MIN_PULSE);
    localparam logic [CNT_BITS-1:0] THR       = CNT_BITS'(THRESH);
    localparam logic [CNT_BITS-1:0] IDLE_LAST = CNT_BITS'(IDLE_TICKS - 1);

    logic                r_din_meta;
    logic                r_din_s;
    logic                r_din_prev;
    rx_state_e           r_state;
    logic [CNT_BITS-1:0] r_hcnt;
    logic [CNT_BITS-1:0] r_lcnt;
    logic [FB-1:0]       r_shadow;
    logic [BC_W-1:0]     r_bitcnt;
    logic                r_fwd;

    logic w_rise;
    logic w_fall;
    logic w_dec;
    logic w_bit;
    logic w_timeout;
    logic w_load;

    always_comb begin
        w_rise    = r_din_s & ~r_din_prev;
        w_fall    = ~r_din_s & r_din_prev;
        w_dec     = (r_state == RX_HIGH) && w_fall && (r_hcnt >= MINP);
        w_bit     = (r_hcnt >= THR);
        w_timeout = (r_state == RX_LOW) && !r_din_s && (r_lcnt == IDLE_LAST);
        w_load    = w_timeout && (r_bitcnt == FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_din_meta <= 1'b0;
            r_din_s    <= 1'b0;
            r_din_prev <= 1'b0;
        end else begin
            r_din_meta <= din;
            r_din_s    <= r_din_meta;
            r_din_prev <= r_din_s;
        end
    end

    // hcnt counts the cycle of the rise too, so it equals the high time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            unique case (r_state)
                RX_IDLE: begin
                    if (w_rise) begin
                        r_state <= RX_HIGH;
                        r_hcnt  <= CNT_BITS'(1);
                    end
                end
                RX_HIGH: begin
                    if (w_fall) begin
                        r_state <= RX_LOW;
                        r_lcnt  <= '0;
                    end else if (r_hcnt != '1) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                RX_LOW: begin
                    if (r_din_s) begin
                        r_state <= RX_HIGH;
                        r_hcnt  <= CNT_BITS'(1);
                        r_lcnt  <= '0;
                    end else if (w_timeout) begin
                        r_state <= RX_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    // The bit that fills the shadow opens forwarding from the next edge on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_bitcnt <= '0;
            r_fwd    <= 1'b0;
        end else if (w_timeout) begin
            r_bitcnt <= '0;
            r_fwd    <= 1'b0;
        end else if (w_dec && (r_bitcnt != FULL)) begin
            r_shadow <= {r_shadow[FB-2:0], w_bit};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == FULL - 1'b1) begin
                r_fwd <= 1'b1;
            end
        end
    end

    assign dout = r_fwd & r_din_s;

    trainled_pwm #(
        .CHANNELS (CHANNELS),
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_frame (r_shadow),
        .o_led   (led)
    );

endmodule

// File: tb/tb_trainled_nch.sv
// Randomised bench for trainled_nch against a pulse-level reference model.
module tb_trainled_nch;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       din   = 1'b0;
    logic       dout;
    logic [2:0] led;

    trainled_nch dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout),
        .led   (led)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int exp_duty[3];
    bit own[$];
    bit d1, d2, f1, f2;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // dout must equal din from two cycles earlier when that bit was
    // part of a forwarded pulse, else 0.
    task automatic step(input bit v, input bit fw);
        @(negedge clk);
        check("dout", 32'(dout), 32'(f2 ? d2 : 1'b0));
        d2  = d1;
        f2  = f1;
        d1  = v;
        f1  = fw;
        din = v;
    endtask

    task automatic pulse(input int h, input int l);
        bit fw;
        fw = (own.size() == 24);
        if (h >= 2 && !fw) own.push_back(h >= 6);
        for (int i = 0; i < h; i++) step(1'b1, fw);
        for (int i = 0; i < l; i++) step(1'b0, fw);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        for (int k = 7; k >= 0; k--) begin
            if (rnd && $urandom_range(7) == 0)
                pulse(1, int'($urandom_range(6, 3)));
            if (b[k])
                pulse(rnd ? int'($urandom_range(12, 6)) : 8,
                      rnd ? int'($urandom_range(8, 3)) : 4);
            else
                pulse(rnd ? int'($urandom_range(5, 2)) : 4,
                      rnd ? int'($urandom_range(8, 3)) : 8);
        end
    endtask

    task automatic end_frame();
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
        if (own.size() == 24) begin
            for (int c = 0; c < 3; c++) begin
                int v;
                v = 0;
                for (int k = 0; k < 8; k++) v = v * 2 + int'(own[c*8+k]);
                exp_duty[c] = v;
            end
        end
        own.delete();
    endtask

    task automatic measure(input string tag);
        int cnt[3];
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
        cnt = '{0, 0, 0};
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0);
            for (int c = 0; c < 3; c++) if (led[c]) cnt[c]++;
        end
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_led%0d", tag, c), cnt[c], exp_duty[c]);
    endtask

    initial begin
        exp_duty = '{0, 0, 0};
        d1 = 0; d2 = 0; f1 = 0; f2 = 0;

        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 0);
        check("rst_dout", 32'(dout), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        check("idle_led", 32'(led), 0);

        send_byte(8'h01, 0); send_byte(8'h04, 0); send_byte(8'h1B, 0);
        end_frame();
        measure("basic");

        send_byte(8'h01, 0); send_byte(8'h04, 0); send_byte(8'h1B, 0);
        send_byte(8'h55, 0);
        end_frame();
        measure("fwd");

        send_byte(8'h10, 0); send_byte(8'h20, 0);
        end_frame();
        measure("partial");

        for (int h = 0; h < 16; h++) begin
            if (h == 0) for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
            else pulse(h, 6);
        end
        while (own.size() < 24) pulse((own.size() % 2) ? 8 : 4, 6);
        end_frame();
        measure("sweep");

        repeat (10) begin
            int nb;
            nb = int'($urandom_range(5, 1));
            for (int i = 0; i < nb; i++) send_byte(8'($urandom), 1);
            end_frame();
            measure("rand");
        end

        send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        end_frame();
        measure("full");

        send_byte(8'hFF, 0);
        for (int i = 0; i < 4; i++) pulse(4, 8);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_led", 32'(led), 0);
        check("midrst_dout", 32'(dout), 0);
        own.delete();
        exp_duty = '{0, 0, 0};
        d1 = 0; d2 = 0; f1 = 0; f2 = 0;
        din = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        measure("post_rst");

        send_byte(8'hFF, 0); send_byte(8'h00, 0); send_byte(8'h80, 0);
        end_frame();
        measure("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
